// File: rtl/uart_host_seq.sv
// Register-bus master for the UART top: programs divisor/line/FIFO
// registers after a start pulse, forwards TX bytes into THR and polls
// LSR to drain RBR into an output byte stream.
module uart_host_seq #(
  parameter logic [15:0] DIV      = 16'd27,
  parameter logic [7:0]  LCR_CFG  = 8'h03,
  parameter logic [7:0]  FCR_CFG  = 8'h01,
  parameter int          POLL_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       uart_wr,
  output logic       uart_rd,
  output logic [2:0] uart_addr,
  output logic [7:0] uart_din,
  input  logic [7:0] uart_dout,
  output logic       cfg_done,
  output logic       busy
);

  localparam int CNT_W = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, C_DLAB, C_DLL, C_DLM, C_LCR, C_FCR,
    READY, TX_WR, P_RD, P_WAIT, R_RD, R_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] poll_cnt, poll_cnt_nxt;
  logic             cfg_done_nxt;
  logic             wr_nxt, rd_nxt, s_ready_nxt, busy_nxt;
  logic [2:0]       addr_nxt;
  logic [7:0]       din_nxt;
  logic             poll_due;

  assign poll_due = (poll_cnt == CNT_MAX) && !m_valid;

  // Next-state, poll counter and bus values for the upcoming cycle; bus
  // outputs are decoded from the next state so the registered strobes
  // line up with the state they belong to.
  always_comb begin
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    cfg_done_nxt = cfg_done;
    wr_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    addr_nxt     = 3'd0;
    din_nxt      = 8'd0;
    s_ready_nxt  = 1'b0;
    busy_nxt     = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = C_DLAB;
      C_DLAB:  state_nxt = C_DLL;
      C_DLL:   state_nxt = C_DLM;
      C_DLM:   state_nxt = C_LCR;
      C_LCR:   state_nxt = C_FCR;
      C_FCR: begin
        state_nxt    = READY;
        cfg_done_nxt = 1'b1;
      end
      READY: begin
        if (start) begin
          state_nxt    = C_DLAB;
          poll_cnt_nxt = '0;
          cfg_done_nxt = 1'b0;
        end else if (poll_due) begin
          state_nxt    = P_RD;
          poll_cnt_nxt = '0;
        end else begin
          if (!m_valid && (poll_cnt != CNT_MAX))
            poll_cnt_nxt = poll_cnt + CNT_W'(1);
          if (s_valid) state_nxt = TX_WR;
        end
      end
      TX_WR:   state_nxt = READY;
      P_RD:    state_nxt = P_WAIT;
      P_WAIT:  state_nxt = uart_dout[0] ? R_RD : READY;
      R_RD:    state_nxt = R_WAIT;
      R_WAIT:  state_nxt = READY;
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      C_DLAB: begin wr_nxt = 1'b1; addr_nxt = 3'd3; din_nxt = LCR_CFG | 8'h80; end
      C_DLL:  begin wr_nxt = 1'b1; addr_nxt = 3'd0; din_nxt = DIV[7:0];        end
      C_DLM:  begin wr_nxt = 1'b1; addr_nxt = 3'd1; din_nxt = DIV[15:8];       end
      C_LCR:  begin wr_nxt = 1'b1; addr_nxt = 3'd3; din_nxt = LCR_CFG;         end
      C_FCR:  begin wr_nxt = 1'b1; addr_nxt = 3'd2; din_nxt = FCR_CFG;         end
      TX_WR:  begin wr_nxt = 1'b1; addr_nxt = 3'd0; din_nxt = s_data; s_ready_nxt = 1'b1; end
      P_RD:   begin rd_nxt = 1'b1; addr_nxt = 3'd5; end
      R_RD:   begin rd_nxt = 1'b1; addr_nxt = 3'd0; end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE) && (state_nxt != READY);
  end

  // State, counter and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      poll_cnt  <= '0;
      cfg_done  <= 1'b0;
      uart_wr   <= 1'b0;
      uart_rd   <= 1'b0;
      uart_addr <= 3'd0;
      uart_din  <= 8'd0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      poll_cnt  <= poll_cnt_nxt;
      cfg_done  <= cfg_done_nxt;
      uart_wr   <= wr_nxt;
      uart_rd   <= rd_nxt;
      uart_addr <= addr_nxt;
      uart_din  <= din_nxt;
      s_ready   <= s_ready_nxt;
      busy      <= busy_nxt;
    end
  end

  // RX output holding register: loaded from RBR data, released on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'd0;
    end else if (state == R_WAIT) begin
      m_valid <= 1'b1;
      m_data  <= uart_dout;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_host_seq.sv
// Bench for uart_host_seq: a small UART register model (RX byte queue
// behind LSR/RBR), bus monitor, directed scenarios and a randomized
// TX/RX stream run compared against queues of sent/received bytes.
module tb_uart_host_seq;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst, start, s_valid, m_ready;
  logic [7:0] s_data;
  logic [7:0] uart_dout = 8'd0;
  logic       s_ready, m_valid, uart_wr, uart_rd, cfg_done, busy;
  logic [7:0] m_data, uart_din;
  logic [2:0] uart_addr;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_fifo[$];
  logic [7:0] tx_log[$];
  int         sr_cyc[$];
  int         cyc = 0, last_sr = -10;
  int         wr_cnt = 0, rd_cnt = 0, both_err = 0, sready_err = 0;

  uart_host_seq #(.DIV(16'h0145), .LCR_CFG(8'h1B), .FCR_CFG(8'h01), .POLL_CYC(P)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .uart_wr(uart_wr), .uart_rd(uart_rd), .uart_addr(uart_addr),
    .uart_din(uart_din), .uart_dout(uart_dout),
    .cfg_done(cfg_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // UART register model and bus monitor.
  always @(posedge clk) begin
    if (uart_rd) begin
      rd_cnt++;
      if (uart_addr == 3'd5)
        uart_dout <= 8'h60 | {7'd0, (rx_fifo.size() != 0)};
      else if (uart_addr == 3'd0 && rx_fifo.size() > 0)
        uart_dout <= rx_fifo.pop_front();
      else
        uart_dout <= 8'd0;
    end
    if (uart_wr) wr_cnt++;
    if (uart_wr && uart_rd) both_err++;
    if (s_ready) begin
      if (!(uart_wr && uart_addr == 3'd0)) sready_err++;
      if (last_sr == cyc - 1) sready_err++;
      tx_log.push_back(uart_din);
      sr_cyc.push_back(cyc);
      last_sr = cyc;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    check("tx_ready_seen", {31'd0, s_ready}, 32'd1);
    tick();
  endtask

  initial begin
    logic [2:0]  ea[5];
    logic [7:0]  ed[5];
    logic [7:0]  tx_b[16];
    logic [7:0]  rx_exp[$];
    logic [7:0]  rx_got[$];
    int          n, rdc, wc, ti;
    logic        found, hs_tx, hs_rx;

    ea = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2};
    ed = '{8'h9B, 8'h45, 8'h01, 8'h1B, 8'h01};

    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
    repeat (3) tick();
    check("rst_bus", {uart_wr, uart_rd, uart_addr, uart_din}, 32'd0);
    check("rst_stat", {s_ready, m_valid, m_data, cfg_done, busy}, 32'd0);
    rst = 1'b1;
    repeat (4) tick();
    check("idle_no_strobe", wr_cnt + rd_cnt, 32'd0);

    // Configuration sequence
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("cfg_bus%0d", i), {uart_wr, uart_rd, uart_addr, uart_din},
            {1'b1, 1'b0, ea[i], ed[i]});
      if (i == 0) check("cfg_busy", {cfg_done, busy}, 32'd1);
      tick();
    end
    check("cfg_done", {cfg_done, busy, uart_wr}, 32'b100);

    // Back-to-back TX bytes
    tx_log.delete();
    sr_cyc.delete();
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    s_valid = 1'b0;
    check("tx_cnt", tx_log.size(), 32'd3);
    if (tx_log.size() == 3) begin
      check("tx0", tx_log[0], 32'hA1);
      check("tx1", tx_log[1], 32'hB2);
      check("tx2", tx_log[2], 32'hC3);
      check("tx_gap01", sr_cyc[1] - sr_cyc[0], 32'd2);
      check("tx_gap12", sr_cyc[2] - sr_cyc[1], 32'd2);
    end

    // Poll vs TX priority: poll falls due P+1 cycles after a P_RD cycle
    found = 1'b0;
    for (n = 0; n < 100 && !found; n++) begin
      if (uart_rd && uart_addr == 3'd5) found = 1'b1;
      else tick();
    end
    check("poll_seen", {31'd0, found}, 32'd1);
    repeat (P + 1) tick();
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick();
    check("prio_poll_first", {uart_rd, uart_addr, s_ready}, {1'b1, 3'd5, 1'b0});
    tick();
    tick();
    check("prio_ready_gap", {31'd0, s_ready}, 32'd0);
    tick();
    check("prio_tx_after", {s_ready, uart_wr, uart_din}, {1'b1, 1'b1, 8'h3C});
    tick();
    s_valid = 1'b0;

    // RX poll with stalled consumer
    rx_fifo.push_back(8'h5A);
    n = 0;
    while (!m_valid && n < 100) begin
      tick();
      n++;
    end
    check("rx_valid", {31'd0, m_valid}, 32'd1);
    check("rx_data", m_data, 32'h5A);
    rdc = rd_cnt;
    repeat (10) tick();
    check("rx_hold", {m_valid, m_data}, {1'b1, 8'h5A});
    check("rx_no_poll", rd_cnt - rdc, 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("rx_clear", {31'd0, m_valid}, 32'd0);
    repeat (P + 4) tick();
    check("rx_poll_resume", {31'd0, (rd_cnt > rdc)}, 32'd1);

    // Randomized concurrent TX/RX streams
    tx_log.delete();
    for (int i = 0; i < 16; i++) tx_b[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      rx_exp.push_back(8'($urandom));
      rx_fifo.push_back(rx_exp[i]);
    end
    ti = 0;
    for (int c = 0; c < 4000 && (ti < 16 || rx_got.size() < 12); c++) begin
      hs_tx = s_valid && s_ready;
      hs_rx = m_valid && m_ready;
      if (hs_rx) rx_got.push_back(m_data);
      tick();
      if (hs_tx) ti++;
      if (!s_valid || hs_tx) begin
        if (ti < 16 && $urandom_range(0, 3) != 0) begin
          s_valid = 1'b1;
          s_data  = tx_b[ti];
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = 1'($urandom_range(0, 1));
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("rnd_tx_cnt", tx_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < tx_log.size(); i++)
      check($sformatf("rnd_tx%0d", i), tx_log[i], tx_b[i]);
    check("rnd_rx_cnt", rx_got.size(), 32'd12);
    for (int i = 0; i < 12 && i < rx_got.size(); i++)
      check($sformatf("rnd_rx%0d", i), rx_got[i], rx_exp[i]);
    tick();

    // Reset in the middle of configuration
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_dlm", {uart_wr, uart_addr, uart_din}, {1'b1, 3'd1, 8'h01});
    rst = 1'b0;
    #1;
    check("mid_rst_bus", {uart_wr, uart_rd, uart_addr, uart_din}, 32'd0);
    check("mid_rst_stat", {s_ready, m_valid, m_data, cfg_done, busy}, 32'd0);
    wc = wr_cnt;
    rdc = rd_cnt;
    tick();
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("mid_no_strobe", (wr_cnt - wc) + (rd_cnt - rdc), 32'd0);
    check("mid_idle", {cfg_done, busy}, 32'd0);

    check("wr_rd_exclusive", both_err, 32'd0);
    check("sready_align", sready_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_host_seq.md
UART_HOST_SEQ -- requirements
Module: uart_host_seq

Upstream register-bus master for the UART top. It programs the line and divisor registers, streams TX bytes into THR, and polls LSR to drain RBR into an output stream.

Interface
REQ-001 SHALL have parameter DIV, default 16'd27, divisor latch value written as DLL = DIV[7:0] and DLM = DIV[15:8].
REQ-002 SHALL have parameter LCR_CFG, default 8'h03 (8N1, DLAB=0), line-control value.
REQ-003 SHALL have parameter FCR_CFG, default 8'h01, FIFO-control value (FIFO enable).
REQ-004 SHALL have parameter POLL_CYC, default 16, number of READY cycles between LSR polls (minimum 2).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  single-cycle pulse that begins the configuration sequence.
REQ-008 s_valid  in  1 / s_data  in  8 / s_ready  out  1  TX byte stream.
REQ-009 m_valid  out  1 / m_data  out  8 / m_ready  in  1  RX byte stream.
REQ-010 uart_wr  out  1 / uart_rd  out  1 / uart_addr  out  3 / uart_din  out  8  bus to the UART top.
REQ-011 uart_dout  in  8  UART read data, valid the cycle after uart_rd.
REQ-012 cfg_done  out  1  configuration complete / busy  out  1  FSM is not in IDLE or READY.

Function
REQ-013 FSM states SHALL be: IDLE, C_DLAB, C_DLL, C_DLM, C_LCR, C_FCR, READY, TX_WR, P_RD, P_WAIT, R_RD, R_WAIT.
REQ-014 IDLE SHALL go to C_DLAB on start; start SHALL be ignored in every state except IDLE and READY.
REQ-015 Each configuration state SHALL last exactly 1 cycle with uart_wr=1, in this order:
  - C_DLAB: addr 3, data LCR_CFG|8'h80
  - C_DLL: addr 0, data DLL
  - C_DLM: addr 1, data DLM
  - C_LCR: addr 3, data LCR_CFG
  - C_FCR: addr 2, data FCR_CFG
  The sequence SHALL then go to READY and set cfg_done=1.
REQ-016 start seen in READY SHALL rerun the sequence from C_DLAB, clear cfg_done, and reset the poll counter.
REQ-017 Poll counter: SHALL increment each READY cycle while m_valid=0 and saturate at POLL_CYC-1; it SHALL clear on entry to P_RD.
REQ-018 READY priority SHALL be, highest first: start, then poll (counter == POLL_CYC-1 and m_valid=0), then TX (s_valid=1).
REQ-019 TX_WR SHALL last 1 cycle with uart_wr=1, addr 0, uart_din=s_data, s_ready=1, then return to READY.
REQ-020 s_ready SHALL be 1 only in TX_WR, so the maximum TX rate is one byte per 2 cycles.
REQ-021 P_RD SHALL assert uart_rd=1 with addr 5 (LSR).
REQ-022 P_WAIT SHALL go to R_RD if uart_dout[0]=1, else to READY.
REQ-023 R_RD SHALL assert uart_rd=1 with addr 0 (RBR).
REQ-024 R_WAIT SHALL load m_data=uart_dout, set m_valid=1, and go to READY.
REQ-025 m_valid SHALL hold with m_data stable until an m_valid&m_ready cycle, then clear the next edge.
REQ-026 While m_valid=1, polling SHALL be suppressed; TX SHALL continue.
REQ-027 uart_wr and uart_rd SHALL never be 1 in the same cycle.
REQ-028 Bus outputs SHALL be registered; uart_addr and uart_din SHALL be 0 whenever neither strobe is active.
REQ-029 Simultaneous m_ready handshake and R_WAIT load SHALL be impossible, because polling is blocked while m_valid=1.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE and set all outputs to 0: uart_wr, uart_rd, uart_addr, uart_din, s_ready, m_valid, m_data, cfg_done, busy. The poll counter SHALL also be 0.
REQ-031 Reset during any sequence SHALL abort it with no further strobes; a new start SHALL be required after release.

Verification
REQ-032 Config order: DIV=16'h0145, LCR_CFG=8'h1B, start pulse -> writes (3,9B), (0,45), (1,01), (3,1B), (2,01) on 5 consecutive cycles, then cfg_done=1 with busy=0.
REQ-033 TX stream: 3 back-to-back bytes A1, B2, C3 with s_valid held -> THR writes of A1, B2, C3, each preceded by a READY cycle, with s_ready pulses aligned to the writes.
REQ-034 RX poll: LSR model returns 8'h61 then RBR returns 8'h5A -> m_valid=1 with m_data=5A; with m_ready=0 for 10 cycles, no LSR read occurs until the handshake.
REQ-035 Priority: poll due and s_valid=1 in the same READY cycle -> P_RD taken first, TX_WR follows on the next READY.
REQ-036 Reset mid-config: rst low in C_DLM -> bus idle at once and cfg_done=0; after release, no writes occur until start.
